rs_syndrome_ctrl: RTL and testbench
===================================

Name: rs_syndrome_ctrl

Overview:
Sequencing and output-buffering controller for the RS syndrome stage. It gates the input AXI-stream codeword into ROOTS_NUM parallel Horner syndrome units and captures their combinational syndromes on the tlast beat. It checks codeword length and flags non-zero syndromes. It presents one syndrome vector per codeword to the key-equation solver through a 2-entry valid/ready buffer, and applies backpressure upstream when that buffer is full.

Parameters:
ROOTS_NUM, 16, number of syndromes (2T), one per Horner unit
N_LEN, 255, expected codeword length in symbols
CNT_W, $clog2(N_LEN+1)+1, symbol counter width (derived; do not override)
BUS_WIDTH_IN_SYMB, SYMB_WIDTH: taken from gf_pkg, not module parameters

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
s_tvalid  input  1  codeword beat valid
s_tready  output  1  controller can accept a beat
s_tdata  input  BUS_WIDTH_IN_SYMB x SYMB_WIDTH  codeword symbols (passed through to units)
s_tlast  input  1  last beat of codeword
s_tkeep  input  BUS_WIDTH_IN_SYMB  symbol-valid mask
u_tvalid  output  1  qualified valid to all Horner units (s_tvalid & s_tready)
u_tdata  output  BUS_WIDTH_IN_SYMB x SYMB_WIDTH  = s_tdata
u_tlast  output  1  = s_tlast
u_tkeep  output  BUS_WIDTH_IN_SYMB  = s_tkeep
syn_i  input  ROOTS_NUM x SYMB_WIDTH  combinational syndrome outputs of units
m_tvalid  output  1  syndrome vector valid
m_tready  input  1  downstream accepts
m_tdata  output  ROOTS_NUM x SYMB_WIDTH  captured syndromes
m_err  output  1  any captured syndrome non-zero
m_len_err  output  1  captured codeword length != N_LEN
frame_cnt  output  16  codewords captured since reset, wraps at 2^16

Behaviour:
- Reset values: s_tready=1 (after reset release), m_tvalid=0, m_tdata=0, m_err=0, m_len_err=0, frame_cnt=0, symb_cnt=0, fifo empty.
- Accept: beat accepted when s_tvalid & s_tready. u_tvalid = s_tvalid & s_tready, so a Horner unit never sees a beat that was not accepted.
- s_tready = (fifo_count < 2). It depends only on registered state; there is no combinational path from m_tready.
- Symbol count: on each accepted non-last beat, symb_cnt += popcount(s_tkeep). Non-last beats must have all s_tkeep bits set; violations still count popcount. symb_cnt saturates at 2^CNT_W-1.
- Capture on accepted tlast beat (same cycle, no extra latency):
  - final = symb_cnt + popcount(s_tkeep).
  - Push entry {syn_i, |syn_i (OR over all symbols), final != N_LEN} into the FIFO.
  - symb_cnt <= 0; frame_cnt <= frame_cnt+1.
  - Entry is visible on m_* the next cycle (1-cycle latency tlast-to-m_tvalid).
- FIFO: 2 entries, pointer-based; fifo_count in {0,1,2}.
  - Push and pop in the same cycle: count unchanged. Push is guaranteed legal because s_tready was 1.
  - Pop on m_tvalid & m_tready. m_tvalid = count != 0. m_* hold stable while m_tvalid & ~m_tready.
- Back-to-back codewords: a single-beat codeword (tvalid & tlast every cycle) sustains 1 vector/cycle while m_tready=1. With m_tready=0, exactly 2 vectors are captured, then s_tready drops.
- Single-beat frame (first beat carries tlast): symb_cnt contributes 0; final = popcount(s_tkeep).
- s_tvalid deasserted mid-codeword: symb_cnt holds; no capture.
- Reset mid-codeword: all state cleared asynchronously. The partial codeword is discarded and nothing is pushed. The next accepted beat is treated as the start of a new frame.
- Arithmetic: popcount is BUS_WIDTH_IN_SYMB-bit to CNT_W, zero-extended. frame_cnt wraps 0xFFFF -> 0x0000.

Test Plan:
- BUS_WIDTH_IN_SYMB=8, N_LEN=255, valid codeword: 31 beats of full tkeep, then last beat tkeep=0x7F with syn_i all zero -> next cycle m_tvalid=1, m_err=0, m_len_err=0, frame_cnt=1.
- Same framing, syn_i[3]=0x5A at tlast -> m_tdata[3]=0x5A, m_err=1, m_len_err=0.
- Short codeword: 30 full beats plus last tkeep=0x01 (241 symbols) -> m_len_err=1; next codeword symb_cnt restarts from 0 and yields m_len_err=0 on a correct 255-symbol frame.
- m_tready=0, three single-beat codewords offered back-to-back -> first two captured; s_tready=0 from the cycle after the second capture; third accepted only after one pop; order preserved; no u_tvalid while s_tready=0.
- aresetn asserted after 10 beats of a codeword -> m_tvalid=0, frame_cnt=0, s_tready=1 after release; next full codeword reports m_len_err=0.
- Random tvalid gaps with random m_tready -> scoreboard: every captured vector equals syn_i at its tlast cycle, delivered in order, none dropped or duplicated.

Source files
------------

// File: rtl/gf_pkg.sv
// Galois-field bus geometry shared by the RS decoder stages.
package gf_pkg;
    parameter int BUS_WIDTH_IN_SYMB = 8;
    parameter int SYMB_WIDTH        = 8;
endpackage

// File: rtl/rs_syndrome_ctrl_if.sv
// Signal bundle of the syndrome controller: codeword in, Horner unit
// fan-out, syndrome inputs and the buffered syndrome vector out.
interface rs_syndrome_ctrl_if #(
    parameter int ROOTS_NUM = 16
);
    localparam int BW = gf_pkg::BUS_WIDTH_IN_SYMB;
    localparam int SW = gf_pkg::SYMB_WIDTH;

    logic                          s_tvalid;
    logic                          s_tready;
    logic [BW-1:0][SW-1:0]         s_tdata;
    logic                          s_tlast;
    logic [BW-1:0]                 s_tkeep;
    logic                          u_tvalid;
    logic [BW-1:0][SW-1:0]         u_tdata;
    logic                          u_tlast;
    logic [BW-1:0]                 u_tkeep;
    logic [ROOTS_NUM-1:0][SW-1:0]  syn_i;
    logic                          m_tvalid;
    logic                          m_tready;
    logic [ROOTS_NUM-1:0][SW-1:0]  m_tdata;
    logic                          m_err;
    logic                          m_len_err;
    logic [15:0]                   frame_cnt;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, s_tkeep, syn_i, m_tready,
        output s_tready, u_tvalid, u_tdata, u_tlast, u_tkeep,
        output m_tvalid, m_tdata, m_err, m_len_err, frame_cnt
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, s_tkeep, syn_i, m_tready,
        input  s_tready, u_tvalid, u_tdata, u_tlast, u_tkeep,
        input  m_tvalid, m_tdata, m_err, m_len_err, frame_cnt
    );
endinterface

// File: rtl/rs_syndrome_ctrl.sv
// RS syndrome stage sequencer: gates beats into the Horner units, captures
// their syndromes on tlast and buffers one vector per codeword (2 deep).
module rs_syndrome_ctrl
    import gf_pkg::*;
#(
    parameter int ROOTS_NUM = 16,
    parameter int N_LEN     = 255
) (
    input  logic              aclk,
    input  logic              aresetn,
    rs_syndrome_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(N_LEN + 1) + 1;

    typedef struct packed {
        logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] syn;
        logic                                 err;
        logic                                 len_err;
    } entry_t;

    logic [CNT_W-1:0] symb_cnt;
    logic [CNT_W-1:0] keep_cnt;
    logic [CNT_W:0]   fin_len;
    logic [15:0]      frame_q;
    entry_t           mem [2];
    entry_t           new_entry;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             push;
    logic             pop;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < BUS_WIDTH_IN_SYMB; i++) begin
            keep_cnt = keep_cnt + CNT_W'(bus.s_tkeep[i]);
        end
    end

    // One extra bit so saturation and the length compare see the carry.
    assign fin_len = {1'b0, symb_cnt} + {1'b0, keep_cnt};

    assign bus.s_tready = (count < 2'd2);
    assign accept       = bus.s_tvalid & bus.s_tready;
    assign push         = accept & bus.s_tlast;
    assign pop          = bus.m_tvalid & bus.m_tready;

    assign bus.u_tvalid = accept;
    assign bus.u_tdata  = bus.s_tdata;
    assign bus.u_tlast  = bus.s_tlast;
    assign bus.u_tkeep  = bus.s_tkeep;

    always_comb begin
        new_entry         = '0;
        new_entry.syn     = bus.syn_i;
        new_entry.err     = |bus.syn_i;
        new_entry.len_err = (fin_len != (CNT_W + 1)'(N_LEN));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            symb_cnt <= '0;
        end else if (push) begin
            symb_cnt <= '0;
        end else if (accept) begin
            symb_cnt <= fin_len[CNT_W] ? '1 : fin_len[CNT_W-1:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_q <= '0;
        end else if (push) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
        end else if (push) begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= ~wr_ptr;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr <= 1'b0;
        end else if (pop) begin
            rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.m_tvalid  = (count != 2'd0);
    assign bus.m_tdata   = mem[rd_ptr].syn;
    assign bus.m_err     = mem[rd_ptr].err;
    assign bus.m_len_err = mem[rd_ptr].len_err;
    assign bus.frame_cnt = frame_q;
endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Randomised scoreboard bench for rs_syndrome_ctrl: a driver models the
// frame length and buffer occupancy, a monitor checks each vector in order.
module tb_rs_syndrome_ctrl;
    localparam int NL = 255;

    typedef struct {
        logic [127:0] syn;
        logic         err;
        logic         len_err;
    } exp_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   checks = 0;
    int   errs = 0;
    int   rdy_pct = 100;
    int   frame_len = 0;
    int   frames = 0;
    exp_t q[$];

    rs_syndrome_ctrl_if #(.ROOTS_NUM(16)) bus ();

    rs_syndrome_ctrl #(.ROOTS_NUM(16), .N_LEN(NL)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string n, input logic [127:0] a,
                       input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Downstream consumer: random m_tready, in-order check of every vector
    always @(posedge aclk) begin
        #1;
        bus.m_tready = ($urandom_range(99) < rdy_pct);
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            chk("m_tvalid", 128'(bus.m_tvalid), 128'(q.size() != 0));
            if (bus.m_tvalid && q.size() != 0) begin
                chk("m_tdata", 128'(bus.m_tdata), q[0].syn);
                chk("m_err", 128'(bus.m_err), 128'(q[0].err));
                chk("m_len_err", 128'(bus.m_len_err), 128'(q[0].len_err));
                if (bus.m_tready) void'(q.pop_front());
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered and left at posedge+1
    task automatic beat(input logic [7:0] keep, input bit last,
                        input logic [127:0] syn);
        bit ok;
        bit rdy;
        logic [63:0] d;
        exp_t e;
        ok = 0;
        d = {$urandom, $urandom};
        bus.s_tvalid = 1'b1;
        bus.s_tkeep  = keep;
        bus.s_tlast  = last;
        bus.s_tdata  = d;
        bus.syn_i    = syn;
        for (int t = 0; t < 300 && !ok; t++) begin
            #1;
            rdy = (q.size() < 2);
            chk("s_tready", 128'(bus.s_tready), 128'(rdy));
            chk("u_tvalid", 128'(bus.u_tvalid), 128'(rdy));
            chk("u_tdata", 128'(bus.u_tdata), 128'(d));
            @(posedge aclk);
            #1;
            if (rdy) begin
                ok = 1;
                frame_len += $countones(keep);
                if (last) begin
                    e.syn     = syn;
                    e.err     = (syn != 0);
                    e.len_err = (frame_len != NL);
                    q.push_back(e);
                    frames++;
                    frame_len = 0;
                    chk("frame_cnt", 128'(bus.frame_cnt), 128'(frames[15:0]));
                end
            end
        end
        if (!ok) begin
            errs++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        bus.s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.s_tvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("u_tvalid_idle", 128'(bus.u_tvalid), 128'(0));
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic frame(input int nfull, input logic [7:0] lk,
                         input logic [127:0] syn, input int gap_pct);
        for (int i = 0; i < nfull; i++) begin
            beat(8'hFF, 1'b0, rnd128());
            if ($urandom_range(99) < gap_pct) idle($urandom_range(1, 3));
        end
        beat(lk, 1'b1, syn);
    endtask

    task automatic drain();
        int t;
        rdy_pct = 100;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            idle(1);
            t++;
        end
        chk("drain", 128'(q.size()), 128'(0));
    endtask

    task automatic do_reset();
        bus.s_tvalid = 1'b0;
        aresetn = 1'b0;
        q.delete();
        frame_len = 0;
        frames = 0;
        #1;
        chk("rst_m_tvalid", 128'(bus.m_tvalid), 128'(0));
        chk("rst_m_tdata", 128'(bus.m_tdata), 128'(0));
        chk("rst_frame_cnt", 128'(bus.frame_cnt), 128'(0));
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("rst_s_tready", 128'(bus.s_tready), 128'(1));
        chk("rst_flags", 128'({bus.m_err, bus.m_len_err}), 128'(0));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [127:0] s;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tlast  = 1'b0;
        bus.syn_i    = '0;
        bus.m_tready = 1'b1;
        @(posedge aclk);
        #1;
        do_reset();

        frame(31, 8'h7F, '0, 0);
        idle(2);
        s = 128'h5A << 24;
        frame(31, 8'h7F, s, 0);
        idle(2);
        frame(30, 8'h01, rnd128(), 0);
        frame(31, 8'h7F, '0, 0);
        drain();

        // Stall downstream: two captures fill the buffer, third waits
        rdy_pct = 0;
        idle(2);
        beat(8'hFF, 1'b1, rnd128());
        beat(8'h0F, 1'b1, '0);
        fork
            beat(8'h01, 1'b1, rnd128());
            begin
                repeat (6) @(posedge aclk);
                rdy_pct = 100;
            end
        join
        drain();

        for (int i = 0; i < 10; i++) beat(8'hFF, 1'b0, rnd128());
        do_reset();
        frame(31, 8'h7F, rnd128(), 0);
        drain();

        rdy_pct = 60;
        for (int f = 0; f < 25; f++) begin
            s = ($urandom_range(1) == 0) ? '0 : rnd128();
            frame($urandom_range(28, 32), 8'($urandom), s, 30);
            if ($urandom_range(3) == 0) idle($urandom_range(1, 4));
        end
        for (int f = 0; f < 20; f++) beat(8'($urandom), 1'b1, rnd128());
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end
endmodule
